hilo_ctrl: RTL and testbench

Issue/retire controller on the HI/LO side of the mult/div datapath. Accepts mult/div requests from the control unit, launches the iterative multiply/divide unit, and stalls the CPU while the unit runs. Captures the unit's `hi_entrance`/`lo_entrance` results into the architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo.

---
 rtl/hilo_pkg.sv | 22 ++
 rtl/hilo_regs.sv | 47 ++++
 rtl/hilo_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_hilo_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO issue/retire controller.
//   - hilo_state_t     : controller FSM states
//   - OP_MULT / OP_DIV : operation select encoding (matches mdControl)
//   - HILO_TIMEOUT_DEF : default WAIT-cycle budget before abandoning an op
//   - word_t           : 32-bit datapath word
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WB     = 2'd3
  } hilo_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int HILO_TIMEOUT_DEF = 40;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO register pair.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset (clears HI/LO)
//   i_hi_we, i_lo_we   : write enables for HI / LO
//   i_hi_wd, i_lo_wd   : write data for HI / LO
//   i_rd_hi            : read select, 1 = HI, 0 = LO
//   o_rd_word          : combinational read of the current (pre-write) value
// The read port shows the value held before any write on the same edge,
// so a read and a write to one register in one cycle returns the old value.
module hilo_regs
  import hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_hi_wd,
  input  logic [31:0] i_lo_wd,
  input  logic        i_rd_hi,
  output logic [31:0] o_rd_word
);

  word_t r_hi;
  word_t r_lo;

  // HI/LO storage with independent write enables
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi <= 32'h0000_0000;
      r_lo <= 32'h0000_0000;
    end else begin
      if (i_hi_we) begin
        r_hi <= i_hi_wd;
      end else begin
        r_hi <= r_hi;
      end
      if (i_lo_we) begin
        r_lo <= i_lo_wd;
      end else begin
        r_lo <= r_lo;
      end
    end
  end

  assign o_rd_word = i_rd_hi ? r_hi : r_lo;

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: issue/retire controller for the HI/LO side of mult/div.
// Launches the iterative mult/div unit, stalls the CPU while it runs,
// retires hi_entrance/lo_entrance into HI/LO and serves mfhi/mflo/mthi/mtlo.
// Ports:
//   clock, reset            : clock, asynchronous active-high reset
//   op_start, op_sel        : mult/div request (sampled in IDLE), 0=mult 1=div
//   regB_out                : divisor, checked for zero when trap enabled
//   md_start, mdControl     : launch pulse and latched op select to the unit
//   md_done                 : unit completion pulse (honoured only in WAIT)
//   hi_entrance/lo_entrance : unit results
//   mfhi/mflo/mthi/mtlo     : HI/LO access strobes, wr_data for writes
//   rd_data, rd_valid       : registered read data and one-cycle qualifier
//   busy                    : stall request (LAUNCH, WAIT, WB)
//   md_timeout              : sticky timeout flag
//   div_zero                : sticky divide-by-zero flag
// Optional feature macro: HILO_DIV0_TRAP_EN (divide-by-zero trap in IDLE).
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = HILO_TIMEOUT_DEF,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] regB_out,
  output logic        md_start,
  output logic        mdControl,
  input  logic        md_done,
  input  logic [31:0] hi_entrance,
  input  logic [31:0] lo_entrance,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        md_timeout,
  output logic        div_zero
);

  hilo_state_t      r_state;
  hilo_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_md_start;
  logic             r_md_ctl;
  logic             r_busy;
  logic             r_timeout;
  logic             r_rd_valid;
  word_t            r_rd_data;
  logic             r_pend_v;
  logic             r_pend_hi;
  logic             w_idle;
  logic             w_accept;
  logic             w_div0_hit;
  logic             w_to_hit;
  logic             w_hi_we;
  logic             w_lo_we;
  word_t            w_hi_wd;
  word_t            w_lo_wd;
  logic             w_rd_hi;
  logic             w_rd_strobe;
  word_t            w_rd_word;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_rd_strobe = mfhi | mflo;
  assign w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef HILO_DIV0_TRAP_EN
  logic r_div_zero;

  assign w_div0_hit = w_idle && op_start && (op_sel == OP_DIV) && (regB_out == 32'h0000_0000);

  // Sticky divide-by-zero flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= r_div_zero | w_div0_hit;
    end
  end

  assign div_zero = r_div_zero;
`else
  logic w_unused_regb;

  assign w_div0_hit    = 1'b0;
  assign w_unused_regb = ^regB_out;
  assign div_zero      = 1'b0;
`endif

  assign w_accept = w_idle && op_start && !w_div0_hit;

  // Next-state, counter and HI/LO write selection
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_hit    = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_wd     = wr_data;
    w_lo_wd     = wr_data;
    case (r_state)
      ST_IDLE: begin
        // CPU writes only land while idle; writes during busy are dropped
        w_hi_we = mthi;
        w_lo_we = mtlo;
        if (w_accept) begin
          w_state_nxt = ST_LAUNCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // md_done wins over a timeout landing on the same edge
        if (md_done) begin
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
          w_hi_wd     = hi_entrance;
          w_lo_wd     = lo_entrance;
          w_state_nxt = ST_WB;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WB: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, counter and registered control outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_md_start <= 1'b0;
      r_md_ctl   <= OP_MULT;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_md_start <= w_accept;
      r_md_ctl   <= w_accept ? op_sel : r_md_ctl;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_timeout  <= r_timeout | w_to_hit;
    end
  end

  // A pending read takes the single read port ahead of a fresh strobe
  assign w_rd_hi = r_pend_v ? r_pend_hi : mfhi;

  // Read service: immediate in IDLE, deferred (one pending slot) while busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'h0000_0000;
      r_pend_v   <= 1'b0;
      r_pend_hi  <= 1'b0;
    end else if (w_idle) begin
      if (r_pend_v) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_rd_word;
        // a strobe arriving while the pending read drains is queued behind it
        r_pend_v   <= w_rd_strobe;
        r_pend_hi  <= mfhi;
      end else if (w_rd_strobe) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_rd_word;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end else begin
      r_rd_valid <= 1'b0;
      if (w_rd_strobe) begin
        r_pend_v  <= 1'b1;
        r_pend_hi <= mfhi;
      end else begin
        r_pend_v  <= r_pend_v;
      end
    end
  end

  hilo_regs u_regs (
    .clock     (clock),
    .reset     (reset),
    .i_hi_we   (w_hi_we),
    .i_lo_we   (w_lo_we),
    .i_hi_wd   (w_hi_wd),
    .i_lo_wd   (w_lo_wd),
    .i_rd_hi   (w_rd_hi),
    .o_rd_word (w_rd_word)
  );

  assign md_start   = r_md_start;
  assign mdControl  = r_md_ctl;
  assign busy       = r_busy;
  assign md_timeout = r_timeout;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed self-checking bench for hilo_ctrl.
// Expected read results are queued when a read is strobed (or when a
// deferred read is due) and compared when rd_valid appears.
module tb_hilo_ctrl;

  logic        clock;
  logic        reset;
  logic        op_start;
  logic        op_sel;
  logic [31:0] regB_out;
  logic        md_start;
  logic        mdControl;
  logic        md_done;
  logic [31:0] hi_entrance;
  logic [31:0] lo_entrance;
  logic        mfhi;
  logic        mflo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        md_timeout;
  logic        div_zero;

  int total = 0;
  int bad   = 0;
  int n_md_start = 0;
  int n_rd_valid = 0;
  int n_pushed   = 0;
  logic [31:0] sb_q[$];

  hilo_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .op_start    (op_start),
    .op_sel      (op_sel),
    .regB_out    (regB_out),
    .md_start    (md_start),
    .mdControl   (mdControl),
    .md_done     (md_done),
    .hi_entrance (hi_entrance),
    .lo_entrance (lo_entrance),
    .mfhi        (mfhi),
    .mflo        (mflo),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .md_timeout  (md_timeout),
    .div_zero    (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
    n_pushed++;
  endtask

  // Scoreboard: every rd_valid must match the oldest queued expectation
  always @(negedge clock) begin
    if (!reset) begin
      if (md_start) n_md_start++;
      if (rd_valid) begin
        n_rd_valid++;
        total++;
        assert (sb_q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_rd_valid observed=%h expected=none", rd_data);
        end
        if (sb_q.size() > 0) begin
          logic [31:0] e;
          e = sb_q.pop_front();
          total++;
          assert (rd_data === e) else begin
            bad++;
            $error("FAIL rd_data observed=%h expected=%h", rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    int exp_md_start;
    reset = 1'b1; op_start = 1'b0; op_sel = 1'b0; regB_out = 32'h0000_0003;
    md_done = 1'b0; hi_entrance = 32'h0; lo_entrance = 32'h0;
    mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0; wr_data = 32'h0;
    exp_md_start = 4;
    cyc(2);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_md_start", {31'h0, md_start}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_timeout", {31'h0, md_timeout}, 32'h0);
    chk("rst_div_zero", {31'h0, div_zero}, 32'h0);
    reset = 1'b0;
    cyc(1);

    // Multiply, md_done after 32 WAIT cycles
    op_start = 1'b1; op_sel = 1'b0;
    cyc(1);
    op_start = 1'b0;
    chk("mult_launch_busy", {31'h0, busy}, 32'h1);
    chk("mult_launch_md_start", {31'h0, md_start}, 32'h1);
    chk("mult_mdControl", {31'h0, mdControl}, 32'h0);
    cyc(1);
    chk("mult_wait_md_start", {31'h0, md_start}, 32'h0);
    cyc(32);
    chk("mult_wait33_busy", {31'h0, busy}, 32'h1);
    md_done = 1'b1; hi_entrance = 32'h0000_0001; lo_entrance = 32'h0000_0002;
    cyc(1);
    md_done = 1'b0;
    chk("mult_wb_busy", {31'h0, busy}, 32'h1);
    cyc(1);
    chk("mult_idle_busy", {31'h0, busy}, 32'h0);
    chk("mult_md_start_count", n_md_start, 32'd1);
    mfhi = 1'b1; push(32'h0000_0001);
    cyc(1);
    mfhi = 1'b0; mflo = 1'b1; push(32'h0000_0002);
    cyc(1);
    mflo = 1'b0;
    cyc(2);

    // Read strobed during busy is deferred and returns the new result
    op_start = 1'b1; op_sel = 1'b1; regB_out = 32'h0000_0007;
    cyc(1);
    op_start = 1'b0;
    cyc(1);
    mflo = 1'b1;
    cyc(1);
    mflo = 1'b0;
    cyc(3);
    md_done = 1'b1; hi_entrance = 32'hCAFE_F00D; lo_entrance = 32'hDEAD_BEEF;
    cyc(1);
    md_done = 1'b0;
    chk("div_wb_mdControl", {31'h0, mdControl}, 32'h1);
    chk("div_wb_rd_valid", {31'h0, rd_valid}, 32'h0);
    cyc(1);
    chk("pend_first_idle_rd_valid", {31'h0, rd_valid}, 32'h0);
    push(32'hDEAD_BEEF);
    cyc(3);
    chk("pend_rd_count", n_rd_valid, 32'd3);

    // Timeout; write accepted alongside op_start; write during busy dropped
    mthi = 1'b1; wr_data = 32'h1111_1111;
    cyc(1);
    mthi = 1'b0; mtlo = 1'b1; wr_data = 32'h2222_2222;
    op_start = 1'b1; op_sel = 1'b0;
    cyc(1);
    mtlo = 1'b0; op_start = 1'b0;
    chk("to_launch_busy", {31'h0, busy}, 32'h1);
    cyc(1);
    mthi = 1'b1; wr_data = 32'h0000_0BAD;
    cyc(1);
    mthi = 1'b0;
    cyc(38);
    chk("to_wait40_busy", {31'h0, busy}, 32'h1);
    chk("to_wait40_flag", {31'h0, md_timeout}, 32'h0);
    cyc(1);
    chk("to_flag", {31'h0, md_timeout}, 32'h1);
    chk("to_busy_drop", {31'h0, busy}, 32'h0);
    md_done = 1'b1; hi_entrance = 32'hFFFF_FFFF; lo_entrance = 32'hEEEE_EEEE;
    cyc(1);
    md_done = 1'b0;
    mfhi = 1'b1; push(32'h1111_1111);
    cyc(1);
    mfhi = 1'b0; mflo = 1'b1; push(32'h2222_2222);
    cyc(1);
    mflo = 1'b0;
    cyc(1);

    // Read and write of HI in one cycle returns the old value; mfhi wins over mflo
    mthi = 1'b1; wr_data = 32'h0000_0005;
    cyc(1);
    mthi = 1'b1; wr_data = 32'h0000_0009; mfhi = 1'b1; push(32'h0000_0005);
    cyc(1);
    mthi = 1'b0; push(32'h0000_0009);
    cyc(1);
    mflo = 1'b1; push(32'h0000_0009);
    cyc(1);
    mfhi = 1'b0; mflo = 1'b0;
    cyc(1);

    // Divide by zero
    op_start = 1'b1; op_sel = 1'b1; regB_out = 32'h0000_0000;
    cyc(1);
    op_start = 1'b0;
`ifdef HILO_DIV0_TRAP_EN
    chk("div0_busy", {31'h0, busy}, 32'h0);
    chk("div0_md_start", {31'h0, md_start}, 32'h0);
    chk("div0_flag", {31'h0, div_zero}, 32'h1);
    cyc(2);
`else
    exp_md_start = 5;
    chk("div0_busy", {31'h0, busy}, 32'h1);
    chk("div0_md_start", {31'h0, md_start}, 32'h1);
    chk("div0_flag", {31'h0, div_zero}, 32'h0);
    cyc(3);
    md_done = 1'b1; hi_entrance = 32'h0000_0033; lo_entrance = 32'h0000_0044;
    cyc(1);
    md_done = 1'b0;
    cyc(1);
    chk("div0_done_busy", {31'h0, busy}, 32'h0);
`endif
    regB_out = 32'h0000_0001;

    // Reset in the middle of WAIT
    op_start = 1'b1; op_sel = 1'b0;
    cyc(1);
    op_start = 1'b0;
    cyc(4);
    chk("rstw_pre_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rstw_busy", {31'h0, busy}, 32'h0);
    chk("rstw_timeout", {31'h0, md_timeout}, 32'h0);
    chk("rstw_rd_data", rd_data, 32'h0);
    chk("rstw_div_zero", {31'h0, div_zero}, 32'h0);
    cyc(1);
    reset = 1'b0;
    md_done = 1'b1; hi_entrance = 32'h0000_00EE; lo_entrance = 32'h0000_00FF;
    cyc(1);
    md_done = 1'b0;
    chk("rstw_late_done_busy", {31'h0, busy}, 32'h0);
    mfhi = 1'b1; push(32'h0000_0000);
    cyc(1);
    mfhi = 1'b0; mflo = 1'b1; push(32'h0000_0000);
    cyc(1);
    mflo = 1'b0;
    cyc(2);

    chk("final_queue_empty", sb_q.size(), 32'd0);
    chk("final_rd_count", n_rd_valid, n_pushed);
    chk("final_md_start_count", n_md_start, exp_md_start);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
